// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file.
// Default index width, zero register and ABI a0 index.
package regfile_pkg;

  localparam int RF_AW = 5;

  typedef logic [RF_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
  localparam int A0_IDX = 10;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// A same-cycle set and clear of one index leaves the bit set.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW = RF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [AW-1:0]     set_idx,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_idx,
  output logic [2**AW-1:0]  busy,
  output logic [AW:0]       pend_cnt
);

  localparam int DEPTH = 2**AW;

  logic             set_v;
  logic             clr_v;
  logic             same;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      cnt_q;

  assign set_v = set_en && (set_idx != '0);
  assign clr_v = clr_en && (clr_idx != '0);
  assign same  = set_v && clr_v && (set_idx == clr_idx);

  // Count deltas track the busy vector exactly.
  assign inc = set_v && !busy_q[set_idx];
  assign dec = clr_v && busy_q[clr_idx] && !same;

  // Next busy vector: clear first, then set so a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_v) busy_d[clr_idx] = 1'b0;
    if (set_v) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector and pending counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_q
              + {{AW{1'b0}}, inc}
              - {{AW{1'b0}}, dec};
    end
  end

  assign busy     = busy_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-through bypass,
// hardwired x0, a0 debug mirror and pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_AW,
  parameter int DATA_WIDTH    = 32,
  parameter int A0_INDEX      = A0_IDX,
  parameter bit BYPASS        = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] ad1,
  input  logic [ADDRESS_WIDTH-1:0] ad2,
  input  logic [ADDRESS_WIDTH-1:0] ad3,
  input  logic                     WE3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  input  logic                     iss_en,
  input  logic [ADDRESS_WIDTH-1:0] iss_rd,
  output logic [DATA_WIDTH-1:0]    ALUop1,
  output logic [DATA_WIDTH-1:0]    regOp2,
  output logic                     busy1,
  output logic                     busy2,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic [ADDRESS_WIDTH:0]   pend_cnt,
  output logic                     idle
);

  localparam int DEPTH = 2**ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  wr_v;
  logic                  byp1;
  logic                  byp2;
  logic                  iss1;
  logic                  iss2;

  assign wr_v = WE3 && (ad3 != '0);

  // Storage: x0 is never written, reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_v) begin
      mem[ad3] <= WD3;
    end
  end

  reg_scoreboard #(
    .AW(ADDRESS_WIDTH)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (iss_en),
    .set_idx (iss_rd),
    .clr_en  (WE3),
    .clr_idx (ad3),
    .busy    (busy),
    .pend_cnt(pend_cnt)
  );

  assign byp1 = BYPASS && wr_v && (ad3 == ad1);
  assign byp2 = BYPASS && wr_v && (ad3 == ad2);
  assign iss1 = iss_en && (iss_rd == ad1);
  assign iss2 = iss_en && (iss_rd == ad2);

  // Read muxes: bypass first, then hardwired zero, then storage.
  always_comb begin
    ALUop1 = '0;
    regOp2 = '0;
    if (byp1)             ALUop1 = WD3;
    else if (ad1 != '0)   ALUop1 = mem[ad1];
    if (byp2)             regOp2 = WD3;
    else if (ad2 != '0)   regOp2 = mem[ad2];
  end

  // Retiring write hides busy unless a new producer issues too.
  assign busy1 = busy[ad1] && !(byp1 && !iss1);
  assign busy2 = busy[ad2] && !(byp2 && !iss2);

  assign a0   = mem[A0_INDEX];
  assign idle = (pend_cnt == '0);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb, bypass and non-bypass builds.
// Both instances share stimulus; expectations are hand-computed.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ad1, ad2, ad3, iss_rd;
  logic        WE3, iss_en;
  logic [31:0] WD3;

  logic [31:0] op1_b, op2_b, a0_b, op1_n, op2_n, a0_n;
  logic        b1_b, b2_b, idle_b, b1_n, b2_n, idle_n;
  logic [5:0]  pc_b, pc_n;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .ad1(ad1), .ad2(ad2), .ad3(ad3),
    .WE3(WE3), .WD3(WD3), .iss_en(iss_en), .iss_rd(iss_rd),
    .ALUop1(op1_b), .regOp2(op2_b), .busy1(b1_b), .busy2(b2_b),
    .a0(a0_b), .pend_cnt(pc_b), .idle(idle_b)
  );

  regfile_sb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .ad1(ad1), .ad2(ad2), .ad3(ad3),
    .WE3(WE3), .WD3(WD3), .iss_en(iss_en), .iss_rd(iss_rd),
    .ALUop1(op1_n), .regOp2(op2_n), .busy1(b1_n), .busy2(b2_n),
    .a0(a0_n), .pend_cnt(pc_n), .idle(idle_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    WE3 = 1'b0; iss_en = 1'b0;
    ad3 = '0; WD3 = '0; iss_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; quiet(); ad1 = '0; ad2 = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ad1 = i[4:0]; ad2 = 5'(31 - i);
      #1;
      total++;
      if (op1_b !== 32'd0 || op2_b !== 32'd0 ||
          op1_n !== 32'd0 || op2_n !== 32'd0)
        $display("FAIL reset_read idx=%0d got %h %h %h %h want 0",
                 i, op1_b, op2_b, op1_n, op2_n);
      else passed++;
    end
    total++;
    if (pc_b !== 6'd0 || idle_b !== 1'b1 || pc_n !== 6'd0)
      $display("FAIL reset_cnt got pc=%0d idle=%b want 0/1", pc_b, idle_b);
    else passed++;
    total++;
    if (b1_b !== 1'b0 || b2_b !== 1'b0 || a0_b !== 32'd0)
      $display("FAIL reset_busy got %b %b a0=%h want 0 0 0",
               b1_b, b2_b, a0_b);
    else passed++;
  endtask

  task automatic test_bypass();
    ad1 = 5'd5; ad2 = 5'd0;
    WE3 = 1'b1; ad3 = 5'd5; WD3 = 32'hDEADBEEF;
    #1;
    total++;
    if (op1_b !== 32'hDEADBEEF)
      $display("FAIL bypass_on got %h want deadbeef", op1_b);
    else passed++;
    total++;
    if (op1_n !== 32'd0)
      $display("FAIL bypass_off got %h want 0", op1_n);
    else passed++;
    tick(); quiet(); #1;
    total++;
    if (op1_n !== 32'hDEADBEEF || op1_b !== 32'hDEADBEEF)
      $display("FAIL write_x5 got %h %h want deadbeef", op1_b, op1_n);
    else passed++;
    total++;
    if (pc_b !== 6'd0 || b1_b !== 1'b0)
      $display("FAIL write_nobusy got pc=%0d busy=%b want 0 0",
               pc_b, b1_b);
    else passed++;
  endtask

  task automatic test_zero();
    ad1 = 5'd0; ad2 = 5'd0;
    WE3 = 1'b1; ad3 = 5'd0; WD3 = 32'h12345678;
    iss_en = 1'b1; iss_rd = 5'd0;
    #1;
    total++;
    if (op1_b !== 32'd0)
      $display("FAIL x0_nobypass got %h want 0", op1_b);
    else passed++;
    tick(); quiet(); #1;
    total++;
    if (op1_b !== 32'd0 || op1_n !== 32'd0 || b1_b !== 1'b0)
      $display("FAIL x0_read got %h %h busy=%b want 0 0 0",
               op1_b, op1_n, b1_b);
    else passed++;
    total++;
    if (pc_b !== 6'd0 || idle_b !== 1'b1)
      $display("FAIL x0_cnt got pc=%0d idle=%b want 0 1", pc_b, idle_b);
    else passed++;
  endtask

  task automatic test_issue();
    iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    iss_rd = 5'd7;
    tick(); quiet();
    ad1 = 5'd3; ad2 = 5'd7;
    #1;
    total++;
    if (pc_b !== 6'd2 || idle_b !== 1'b0 || pc_n !== 6'd2)
      $display("FAIL issue_cnt got %0d/%0d idle=%b want 2 0",
               pc_b, pc_n, idle_b);
    else passed++;
    total++;
    if (b1_b !== 1'b1 || b2_b !== 1'b1 || b1_n !== 1'b1)
      $display("FAIL issue_busy got %b %b %b want 1 1 1",
               b1_b, b2_b, b1_n);
    else passed++;
    WE3 = 1'b1; ad3 = 5'd3; WD3 = 32'd7;
    #1;
    total++;
    if (b1_b !== 1'b0 || b1_n !== 1'b1 || b2_b !== 1'b1)
      $display("FAIL wb_busy got b=%b nb=%b b2=%b want 0 1 1",
               b1_b, b1_n, b2_b);
    else passed++;
    total++;
    if (op1_b !== 32'd7 || op1_n !== 32'd0)
      $display("FAIL wb_data got %h %h want 7 0", op1_b, op1_n);
    else passed++;
    tick(); quiet(); #1;
    total++;
    if (pc_b !== 6'd1 || b1_b !== 1'b0 || b1_n !== 1'b0)
      $display("FAIL wb_retire got pc=%0d busy=%b %b want 1 0 0",
               pc_b, b1_b, b1_n);
    else passed++;
    total++;
    if (op1_n !== 32'd7)
      $display("FAIL wb_store got %h want 7", op1_n);
    else passed++;
  endtask

  task automatic test_back_to_back();
    iss_en = 1'b1; iss_rd = 5'd4;
    tick(); quiet(); #1;
    total++;
    if (pc_b !== 6'd2)
      $display("FAIL x4_issue got %0d want 2", pc_b);
    else passed++;
    iss_en = 1'b1; iss_rd = 5'd4;
    WE3 = 1'b1; ad3 = 5'd4; WD3 = 32'd9;
    tick(); quiet();
    ad1 = 5'd4; ad2 = 5'd7;
    #1;
    total++;
    if (op1_b !== 32'd9 || op1_n !== 32'd9)
      $display("FAIL same_data got %h %h want 9", op1_b, op1_n);
    else passed++;
    total++;
    if (b1_b !== 1'b1 || pc_b !== 6'd2 || pc_n !== 6'd2)
      $display("FAIL same_busy got busy=%b pc=%0d want 1 2", b1_b, pc_b);
    else passed++;
  endtask

  task automatic test_a0_reset();
    WE3 = 1'b1; ad3 = 5'd10; WD3 = 32'h55;
    #1;
    total++;
    if (a0_b !== 32'd0)
      $display("FAIL a0_nobypass got %h want 0", a0_b);
    else passed++;
    tick(); quiet(); #1;
    total++;
    if (a0_b !== 32'h55 || a0_n !== 32'h55)
      $display("FAIL a0_write got %h %h want 55", a0_b, a0_n);
    else passed++;
    iss_en = 1'b1; iss_rd = 5'd9;
    tick(); quiet(); #1;
    total++;
    if (pc_b !== 6'd3)
      $display("FAIL three_busy got %0d want 3", pc_b);
    else passed++;
    rst = 1'b1;
    WE3 = 1'b1; ad3 = 5'd4; WD3 = 32'hAA;
    iss_en = 1'b1; iss_rd = 5'd5;
    tick(); rst = 1'b0; quiet();
    ad1 = 5'd4; ad2 = 5'd5;
    #1;
    total++;
    if (a0_b !== 32'd0 || pc_b !== 6'd0 || idle_b !== 1'b1)
      $display("FAIL rst_mid got a0=%h pc=%0d idle=%b want 0 0 1",
               a0_b, pc_b, idle_b);
    else passed++;
    total++;
    if (op1_b !== 32'd0 || b1_b !== 1'b0 || b2_b !== 1'b0)
      $display("FAIL rst_ignore got %h busy=%b %b want 0 0 0",
               op1_b, b1_b, b2_b);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero();
    test_issue();
    test_back_to_back();
    test_a0_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with write-through bypass, hardwired-zero register 0, a dedicated a0 debug output and an integrated pending-write scoreboard. It sits in the decode stage of the pipelined RISC-V core. The decoder reads it through two combinational ports, and the writeback stage writes it through one synchronous port. Busy bits let hazard logic stall on registers whose producing instruction has issued but not yet written back.

## Interface
Parameters:
- ADDRESS_WIDTH, 5: register index width; depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32: register width.
- A0_INDEX, 10: register mirrored on `a0` (ABI a0 = x10).
- BYPASS, 1: 1 = same-cycle writeback forwarded to read ports; 0 = read stored value only.

Ports:
- clk  in  1: single clock, all state updates on rising edge.
- rst  in  1: reset, synchronous, active-high.
- ad1  in  ADDRESS_WIDTH: read port 1 index.
- ad2  in  ADDRESS_WIDTH: read port 2 index.
- ad3  in  ADDRESS_WIDTH: write index.
- WE3  in  1: write enable; also retires the pending write for `ad3`.
- WD3  in  DATA_WIDTH: write data.
- iss_en  in  1: an instruction with destination `iss_rd` issues this cycle.
- iss_rd  in  ADDRESS_WIDTH: destination of the issuing instruction.
- ALUop1  out  DATA_WIDTH: read data, port 1.
- regOp2  out  DATA_WIDTH: read data, port 2.
- busy1  out  1: `ad1` has a pending write.
- busy2  out  1: `ad2` has a pending write.
- a0  out  DATA_WIDTH: stored value of register A0_INDEX.
- pend_cnt  out  ADDRESS_WIDTH+1: number of set busy bits.
- idle  out  1: `pend_cnt == 0`.

## Operation
- Storage: 2**ADDRESS_WIDTH entries of DATA_WIDTH bits. Entry 0 always reads 0. Writes to 0 are discarded. Issues to 0 are discarded.
- Write: on a rising edge with `WE3 && ad3 != 0` and `!rst`, `reg[ad3] <= WD3`.
- Read port n, with bypass condition `BYPASS && WE3 && ad3 == adn && adn != 0`:
  - condition true: output `WD3`.
  - `adn == 0`: output 0.
  - otherwise: output `reg[adn]`.
- `a0` always shows the stored value, never the bypassed value.
- Scoreboard: one busy bit per register; bit 0 is constant 0. On a rising edge:
  - `WE3 && ad3 != 0` clears `busy[ad3]`.
  - `iss_en && iss_rd != 0` sets `busy[iss_rd]`.
  - Set and clear of the same index in the same cycle: set wins, because a newer producer is pending.
- Busy outputs:
  - `busyn = busy[adn]`, except that with BYPASS=1 it reads 0 when the bypass condition for port n holds.
  - Exception to the exception: if `iss_en && iss_rd == adn` in the same cycle, the combinational busy view ignores the same-cycle issue. It reflects registered state only.
- `pend_cnt` is a registered counter updated with the set/clear deltas of each edge:
  - +1 if the set hits a clear bit.
  - −1 if the clear hits a set bit.
  - Net 0 for a same-index set and clear.
  - It must always equal the popcount of the busy vector.
- A WE3 to an index that is not busy is legal: data is written, busy is unchanged, and the count is unchanged.

## Timing
- Read latency 0 (combinational). Write and scoreboard latency 1 edge.
- Reset (sync): while `rst` is high at an edge, all registers become 0, all busy bits 0, and `pend_cnt` 0. WE3 and iss_en are ignored in that cycle.
- Outputs the cycle after reset: `ALUop1 = regOp2 = a0 = 0`, `busy1 = busy2 = 0`, `pend_cnt = 0`, `idle = 1`.
- Reset asserted mid-operation discards all pending writes and busy state. No partial update.
- With BYPASS=0, a read in the write cycle returns the old value and `busyn` stays 1 until the next edge.

## Structure
- Shared package `regfile_pkg`: `REG_ZERO = '0`, `A0_IDX = 10`, and typedef `reg_idx_t` (logic [ADDRESS_WIDTH-1:0]) for the default width.
- Sub-module `reg_scoreboard`: owns the busy vector, `pend_cnt`, and the set/clear priority. Its ports are clk, rst, the set and clear strobes with their indices, and the busy vector out. The top module owns the storage array, the read muxes and the bypass.
- Target: roughly 150–250 lines total.

## Test plan
- Reset then read all 32 indices → every read is 0, `idle = 1`, `pend_cnt = 0`.
- Write x5 = 0xDEADBEEF with WE3 and `ad1 = 5` in the same cycle:
  - BYPASS=1 → `ALUop1 = 0xDEADBEEF` in that cycle.
  - BYPASS=0 → `ALUop1 = 0` that cycle and `0xDEADBEEF` the next.
- Write x0 = 0x12345678 and issue x0 → x0 reads 0, `busy` is unchanged, `pend_cnt = 0`.
- Issue x3, then x7:
  - → `pend_cnt = 2`; `busy1 = 1` for `ad1 = 3`.
  - Writeback x3 = 7 → `busy1 = 0` with BYPASS=1 in the writeback cycle, `pend_cnt = 1` after the edge.
- Same cycle issue x4 and writeback x4 = 9 with x4 already busy → x4 = 9, x4 stays busy, `pend_cnt` unchanged.
- Write x10 = 0x55 → `a0 = 0x55` from the next cycle. Assert `rst` with 3 registers busy → next cycle `a0 = 0`, `pend_cnt = 0`, `idle = 1`.
